// File: rtl/stack_ctrl_pkg.sv
// stack_ctrl_pkg: shared state encoding, op/owner codes and state-class helpers for the stack controller.
package stack_ctrl_pkg;
   typedef enum logic [3:0] {
      S_IDLE, S_PUSH, S_POP_RD, S_PUSH_HI, S_PUSH_LO,
      S_POP_LO, S_POP_HI, S_POP_CAP, S_ERR, S_DONE
   } state_t;
   typedef enum logic {OWN_EX, OWN_INT} own_t;
   localparam logic OP_PUSH = 1'b1;
   localparam logic OP_POP  = 1'b0;
   function automatic logic is_push(state_t s);
      return s inside {S_PUSH, S_PUSH_HI, S_PUSH_LO};
   endfunction
   function automatic logic is_pop(state_t s);
      return s inside {S_POP_RD, S_POP_LO, S_POP_HI};
   endfunction
endpackage

// File: rtl/stack_ctrl_sp.sv
// stack_ctrl_sp: stack pointer register (grows downward from all-ones) with
// push/pop bound checks for an n-word access.
module stack_ctrl_sp #(
   parameter int AW   = 10,
   parameter int BASE = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          inc,
   input  logic          dec,
   input  logic [1:0]    n,
   output logic [AW-1:0] sp,
   output logic [AW-1:0] sp_nxt,
   output logic          push_ok,
   output logic          pop_ok
);
   localparam logic [AW:0] TOP_X  = (AW+1)'(2**AW - 1);
   localparam logic [AW:0] BASE_X = (AW+1)'(BASE);
   logic [AW-1:0] sp_q, sp_d;
   logic [AW:0]   sp_x;
   always_comb begin
      sp_d    = sp_q + AW'(inc) - AW'(dec);
      sp_x    = {1'b0, sp_q};
      push_ok = sp_x + (AW+1)'(1) >= BASE_X + (AW+1)'(n);
      pop_ok  = sp_x + (AW+1)'(n) <= TOP_X;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) sp_q <= '1;
      else     sp_q <= sp_d;
   assign sp     = sp_q;
   assign sp_nxt = sp_d;
endmodule

// File: rtl/stack_ctrl.sv
// stack_ctrl: arbitrates the data-memory stack between execute-stage PUSH/POP and
// interrupt-unit PC save/restore; all strobes and handshakes are registered.
module stack_ctrl
   import stack_ctrl_pkg::*;
#(
   parameter int AW   = 10,
   parameter int DW   = 16,
   parameter int BASE = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ex_req,
   input  logic            ex_op,
   input  logic [DW-1:0]   ex_wdata,
   output logic            ex_gnt,
   output logic            ex_done,
   output logic [DW-1:0]   ex_rdata,
   input  logic            int_req,
   input  logic            int_op,
   input  logic [2*DW-1:0] int_pc,
   output logic            int_gnt,
   output logic            int_done,
   output logic [2*DW-1:0] int_pc_out,
   output logic            mem_we,
   output logic            mem_re,
   output logic [AW-1:0]   mem_addr,
   output logic [DW-1:0]   mem_wdata,
   input  logic [DW-1:0]   mem_rdata,
   output logic [AW-1:0]   sp_out,
   output logic            stk_err
);
   state_t          state_q, state_d;
   own_t            own_q, own_d;
   logic            err_q, err_d, we_q, we_d, re_q, re_d;
   logic            egnt_q, egnt_d, ignt_q, ignt_d, edone_q, edone_d, idone_q, idone_d, serr_q, serr_d;
   logic [2*DW-1:0] data_q, data_d, pc_out_q, pc_out_d;
   logic [DW-1:0]   rdata_q, rdata_d, wdata_q, wdata_d;
   logic [AW-1:0]   addr_q, addr_d, sp, sp_nxt;
   logic            acc_int, acc_ex, ok, push_ok, pop_ok, cap;
   logic [1:0]      n;
   stack_ctrl_sp #(.AW(AW), .BASE(BASE)) u_sp (
      .clk(clk), .rst(rst), .inc(is_pop(state_q)), .dec(is_push(state_q)), .n(n),
      .sp(sp), .sp_nxt(sp_nxt), .push_ok(push_ok), .pop_ok(pop_ok)
   );
   always_comb begin
      acc_int = state_q == S_IDLE && int_req;
      acc_ex  = state_q == S_IDLE && !int_req && ex_req;
      n       = int_req ? 2'd2 : 2'd1;
      ok      = (int_req ? int_op : ex_op) == OP_PUSH ? push_ok : pop_ok;
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (acc_int || acc_ex)
                       state_d = !ok ? S_ERR :
                                 acc_int ? (int_op == OP_PUSH ? S_PUSH_HI : S_POP_LO) :
                                           (ex_op == OP_PUSH ? S_PUSH : S_POP_RD);
         S_PUSH_HI: state_d = S_PUSH_LO;
         S_POP_RD:  state_d = S_POP_CAP;
         S_POP_LO:  state_d = S_POP_HI;
         S_POP_HI:  state_d = S_POP_CAP;
         S_DONE:    state_d = S_IDLE;
         default:   state_d = S_DONE;
      endcase
      own_d  = acc_int ? OWN_INT : acc_ex ? OWN_EX : own_q;
      err_d  = (acc_int || acc_ex) ? !ok : err_q;
      // low half doubles as the RTI low-word capture so int_pc_out updates atomically
      data_d = acc_int ? int_pc : acc_ex ? {{DW{1'b0}}, ex_wdata} :
               state_q == S_POP_HI ? {data_q[2*DW-1:DW], mem_rdata} : data_q;
      we_d    = is_push(state_d);
      re_d    = is_pop(state_d);
      addr_d  = we_d ? sp_nxt : re_d ? sp_nxt + AW'(1) : '0;
      wdata_d = state_d == S_PUSH_HI ? data_d[2*DW-1:DW] : we_d ? data_d[DW-1:0] : '0;
      egnt_d  = acc_ex;
      ignt_d  = acc_int;
      edone_d = state_d == S_DONE && own_d == OWN_EX;
      idone_d = state_d == S_DONE && own_d == OWN_INT;
      serr_d  = state_d == S_DONE && err_d;
      cap     = state_q == S_POP_CAP;
      rdata_d  = cap && own_q == OWN_EX ? mem_rdata : rdata_q;
      pc_out_d = cap && own_q == OWN_INT ? {mem_rdata, data_q[DW-1:0]} : pc_out_q;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q  <= S_IDLE;
         own_q    <= OWN_EX;
         err_q    <= 1'b0;
         data_q   <= '0;
         we_q     <= 1'b0;
         re_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         egnt_q   <= 1'b0;
         ignt_q   <= 1'b0;
         edone_q  <= 1'b0;
         idone_q  <= 1'b0;
         serr_q   <= 1'b0;
         rdata_q  <= '0;
         pc_out_q <= '0;
      end else begin
         state_q  <= state_d;
         own_q    <= own_d;
         err_q    <= err_d;
         data_q   <= data_d;
         we_q     <= we_d;
         re_q     <= re_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         egnt_q   <= egnt_d;
         ignt_q   <= ignt_d;
         edone_q  <= edone_d;
         idone_q  <= idone_d;
         serr_q   <= serr_d;
         rdata_q  <= rdata_d;
         pc_out_q <= pc_out_d;
      end
   assign ex_gnt     = egnt_q;
   assign ex_done    = edone_q;
   assign ex_rdata   = rdata_q;
   assign int_gnt    = ignt_q;
   assign int_done   = idone_q;
   assign int_pc_out = pc_out_q;
   assign mem_we     = we_q;
   assign mem_re     = re_q;
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
   assign sp_out     = sp;
   assign stk_err    = serr_q;
endmodule
